// File: rtl/bus_fabric.sv
// bus_fabric: memory-mapped address decoder and access sequencer.
//
// The top SEL_W address bits are decoded against a table of SLOTS
// base/mask regions. The lowest matching index wins. A mapped access
// holds one chip select for 1+SLOT_WAIT[slot] cycles. cpu_ready pulses
// in the last of those cycles. An unmapped access, or one with both
// cpu_r and cpu_w high, completes one cycle after it is sampled with
// cpu_ready and cpu_fault pulsed together. That fault is also recorded
// in fault_addr and fault_count.
//
// Handshake: the CPU raises exactly one of cpu_r/cpu_w with a stable
// address. It holds the request until it sees the one-cycle cpu_ready
// pulse, then drops it. The fabric does not start another access until
// it has sampled both strobes low.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   cpu_address  CPU address bus (ADDR_W)
//   cpu_r/cpu_w  CPU read / write request, held until cpu_ready
//   cpu_ready    one-cycle completion pulse
//   cpu_fault    one-cycle pulse alongside cpu_ready on a faulted access
//   cs           one-hot peripheral chip selects (SLOTS)
//   slot_r/w     read / write strobe to the selected peripheral
//   fault_addr   address of the most recent faulted access
//   fault_count  saturating count of faulted accesses
module bus_fabric #(
  parameter int ADDR_W = 16,
  parameter int SEL_W  = 4,
  parameter int SLOTS  = 4,
  parameter logic [SLOTS*SEL_W-1:0] SLOT_BASE = {4'hF, 4'hA, 4'h9, 4'h0},
  parameter logic [SLOTS*SEL_W-1:0] SLOT_MASK = {4'hF, 4'hF, 4'hF, 4'h8},
  parameter logic [SLOTS*4-1:0]     SLOT_WAIT = {4'd1, 4'd0, 4'd0, 4'd0}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_r,
  input  logic              cpu_w,
  output logic              cpu_ready,
  output logic              cpu_fault,
  output logic [SLOTS-1:0]  cs,
  output logic              slot_r,
  output logic              slot_w,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [7:0]        fault_count
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  // Kept as a named signal so checkers can bind to the sequencer state.
  state_t state;

  logic [SEL_W-1:0] sel;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [3:0]       hit_wait;
  logic [3:0]       wait_q;
  logic [3:0]       counter;

  // The loop runs from the top index downward, so the last assignment
  // comes from the lowest matching slot.
  always_comb begin
    sel      = cpu_address[ADDR_W-1 -: SEL_W];
    hit      = 1'b0;
    hit_idx  = '0;
    hit_wait = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (((sel ^ SLOT_BASE[i*SEL_W +: SEL_W]) & SLOT_MASK[i*SEL_W +: SEL_W]) == '0) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_wait = SLOT_WAIT[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cs          <= '0;
      slot_r      <= 1'b0;
      slot_w      <= 1'b0;
      cpu_ready   <= 1'b0;
      cpu_fault   <= 1'b0;
      fault_addr  <= '0;
      fault_count <= '0;
      wait_q      <= '0;
      counter     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_r || cpu_w) begin
            if ((cpu_r ^ cpu_w) && hit) begin
              // The slot and the wait count are captured here. Later
              // address changes cannot move the access.
              state     <= ACCESS;
              cs        <= SLOTS'(1) << hit_idx;
              slot_r    <= cpu_r;
              slot_w    <= cpu_w;
              wait_q    <= hit_wait;
              counter   <= '0;
              cpu_ready <= (hit_wait == 4'd0);
            end else begin
              // An unmapped address and a read+write collision take the
              // same fault path.
              state      <= RELEASE;
              cpu_ready  <= 1'b1;
              cpu_fault  <= 1'b1;
              fault_addr <= cpu_address;
              if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
            end
          end
        end
        ACCESS: begin
          if (counter == wait_q) begin
            state     <= RELEASE;
            cs        <= '0;
            slot_r    <= 1'b0;
            slot_w    <= 1'b0;
            cpu_ready <= 1'b0;
          end else begin
            // cpu_ready is registered, so it is raised one edge before
            // the counter reaches wait_q. It then lines up with the last
            // cs cycle.
            counter   <= counter + 4'd1;
            cpu_ready <= ((counter + 4'd1) == wait_q);
          end
        end
        RELEASE: begin
          cpu_ready <= 1'b0;
          cpu_fault <= 1'b0;
          if (!cpu_r && !cpu_w) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed scoreboard bench for bus_fabric (default parameters).
// The driver issues accesses and pushes the expected completion response
// {cpu_fault, cs, slot_r, slot_w} into exp_q. The monitor pops and compares
// one entry on every cpu_ready pulse.
module tb_bus_fabric;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_r, cpu_w;
  logic        cpu_ready, cpu_fault;
  logic [3:0]  cs;
  logic        slot_r, slot_w;
  logic [15:0] fault_addr;
  logic [7:0]  fault_count;

  int tests = 0;
  int fails = 0;
  int exp_fc = 0;
  logic [6:0] exp_q[$];

  bus_fabric dut (
    .clk(clk), .reset(reset), .cpu_address(cpu_address),
    .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_ready(cpu_ready), .cpu_fault(cpu_fault),
    .cs(cs), .slot_r(slot_r), .slot_w(slot_w),
    .fault_addr(fault_addr), .fault_count(fault_count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: chip selects are one-hot or zero in every cycle. Each ready
  // pulse is checked against the oldest expected response.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cs_onehot0", {31'b0, $onehot0(cs)}, 32'd1);
      if (cpu_ready) begin
        if (exp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
        else chk("ready_resp", {25'b0, cpu_fault, cs, slot_r, slot_w}, {25'b0, exp_q.pop_front()});
      end
    end
  end

  // Driver: issue one access and measure its latency and its cs length.
  // The address is scrambled after the request edge to show that it is
  // ignored. The strobe is held `hold` cycles past ready.
  task automatic do_access(input string name, input logic [15:0] addr, input logic r,
                           input logic w, input int wt, input bit flt,
                           input logic [3:0] exp_cs, input int hold);
    int cyc = 0;
    int cs_cyc = 0;
    @(negedge clk);
    cpu_address = addr; cpu_r = r; cpu_w = w;
    exp_q.push_back(flt ? 7'b1_0000_00 : {1'b0, exp_cs, r, w});
    if (flt) exp_fc = (exp_fc < 255) ? exp_fc + 1 : 255;
    do begin
      @(negedge clk);
      cyc++;
      cpu_address = ~addr;
      if (cs != 4'b0) begin
        cs_cyc++;
        chk({name, "_cs"}, {28'b0, cs}, {28'b0, exp_cs});
      end
    end while (!cpu_ready && cyc < 40);
    chk({name, "_latency"}, cyc, flt ? 1 : wt + 1);
    chk({name, "_cs_cycles"}, cs_cyc, flt ? 0 : wt + 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_held_quiet"}, {27'b0, cs, cpu_ready}, 32'd0);
    end
    cpu_r = 1'b0; cpu_w = 1'b0;
    @(negedge clk);
    chk({name, "_release"}, {26'b0, cs, slot_r, slot_w}, 32'd0);
    chk({name, "_fault_count"}, {24'b0, fault_count}, exp_fc);
    if (flt) chk({name, "_fault_addr"}, {16'b0, fault_addr}, {16'b0, addr});
  endtask

  initial begin
    reset = 1'b1; cpu_address = '0; cpu_r = 1'b0; cpu_w = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'b0, cs, slot_r, slot_w, cpu_ready, cpu_fault, fault_count}, 32'd0);
    chk("reset_fault_addr", {16'b0, fault_addr}, 32'd0);
    chk("reset_state", 32'(dut.state), 32'd0);
    reset = 1'b0;

    do_access("rd_ram",    16'h0123, 1'b1, 1'b0, 0, 1'b0, 4'b0001, 0);
    do_access("wr_slot3",  16'hF010, 1'b0, 1'b1, 1, 1'b0, 4'b1000, 0);
    do_access("rd_slot2",  16'hA55A, 1'b1, 1'b0, 0, 1'b0, 4'b0100, 0);
    do_access("unmapped",  16'hC000, 1'b1, 1'b0, 0, 1'b1, 4'b0000, 0);
    do_access("rw_both",   16'h9000, 1'b1, 1'b1, 0, 1'b1, 4'b0000, 0);
    do_access("held_rd",   16'h9004, 1'b1, 1'b0, 0, 1'b0, 4'b0010, 5);
    do_access("after_hold",16'h9004, 1'b1, 1'b0, 0, 1'b0, 4'b0010, 0);

    // 298 more faults give 300 in total, which must stop at 255.
    for (int i = 0; i < 298; i++)
      do_access("sat", 16'hC000, 1'b1, 1'b0, 0, 1'b1, 4'b0000, 0);
    chk("fault_saturated", {24'b0, fault_count}, 32'd255);

    // Reset in the first cycle of a W=1 access aborts it with no ready.
    @(negedge clk);
    cpu_address = 16'hF000; cpu_w = 1'b1;
    @(negedge clk);
    chk("abort_cs_before", {28'b0, cs}, 32'h8);
    reset = 1'b1; cpu_w = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {19'b0, cs, slot_r, slot_w, cpu_ready, cpu_fault, fault_count}, 32'd0);
    chk("abort_state", 32'(dut.state), 32'd0);
    reset = 1'b0;
    exp_fc = 0;

    do_access("post_reset", 16'h0123, 1'b1, 1'b0, 0, 1'b0, 4'b0001, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
